ipm2l_apm_pipeline_credit_buffer: RTL

//  Downstream stage of the APM distributed shift-register delay line. The delay line has no stall input.

---
 rtl/ipm2l_apm_pipeline_credit_buffer_if.sv | 32 +++
 rtl/ipm2l_apm_pipeline_credit_buffer.sv | 76 +++++++
 2 files changed

// File: rtl/ipm2l_apm_pipeline_credit_buffer_if.sv
// rtl/ipm2l_apm_pipeline_credit_buffer_if.sv - issue, delay-line return and output stream bundle
interface ipm2l_apm_pipeline_credit_buffer_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic                  pipe_valid;
  logic [DATA_WIDTH-1:0] pipe_data;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_ready;

  modport slave (
    input  in_valid,
    output in_ready,
    input  pipe_valid,
    input  pipe_data,
    output out_valid,
    output out_data,
    input  out_ready
  );

  modport master (
    output in_valid,
    input  in_ready,
    output pipe_valid,
    output pipe_data,
    input  out_valid,
    input  out_data,
    output out_ready
  );
endinterface

// File: rtl/ipm2l_apm_pipeline_credit_buffer.sv
// rtl/ipm2l_apm_pipeline_credit_buffer.sv - credit-gated issue plus FWFT catch FIFO behind a stall-less delay line
module ipm2l_apm_pipeline_credit_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int LATENCY    = 16,
  parameter int FIFO_DEPTH = 32,
  localparam int CW        = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                             clk,
  input  logic                             rst,
  ipm2l_apm_pipeline_credit_buffer_if.slave bus,
  output logic [CW-1:0]                    credit_cnt,
  output logic [CW-1:0]                    fill_cnt,
  output logic                             overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic                  in_fire;
  logic                  out_fire;
  logic                  full;
  logic                  empty;
  logic                  wr_en;

  // Below LATENCY+1 entries the credit loop, not the source, limits throughput.
  if (FIFO_DEPTH < LATENCY + 1) begin : g_credit_limited
  end

  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty    = (wr_ptr == rd_ptr);
  assign fill_cnt = CW'(wr_ptr - rd_ptr);

  assign bus.in_ready  = (credit_cnt != '0);
  assign bus.out_valid = !empty;
  assign bus.out_data  = mem[rd_ptr[AW-1:0]];

  assign in_fire  = bus.in_valid && bus.in_ready;
  assign out_fire = bus.out_valid && bus.out_ready;
  // A full FIFO still accepts when the head leaves on the same edge.
  assign wr_en    = bus.pipe_valid && (!full || out_fire);

  always_ff @(posedge clk) begin
    if (rst) begin
      credit_cnt <= CW'(FIFO_DEPTH);
    end else if (in_fire && !out_fire) begin
      credit_cnt <= credit_cnt - 1'b1;
    end else if (out_fire && !in_fire && credit_cnt != CW'(FIFO_DEPTH)) begin
      credit_cnt <= credit_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (out_fire) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (bus.pipe_valid && !wr_en) begin
        overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr[AW-1:0]] <= bus.pipe_data;
    end
  end
endmodule
